// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the vending machine UART transmitter and receivers:
// state encoding, default line parameters and frame geometry.
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEFAULT  = 100_000_000;
  localparam int unsigned BAUD_RATE_DEFAULT = 9_600;
  localparam int unsigned NUM_BIT           = 10;
  localparam int unsigned DATA_BITS         = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Counter width for a divider of 'ticks' clocks; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
`timescale 1ns/1ps
// Bit-period divider: counts 0..bit_ticks-1 and flags the last clock of each bit.
// Held at zero while clear is asserted so a new frame always starts on a full bit.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned bit_ticks = CLK_FREQ_DEFAULT / BAUD_RATE_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = cnt_width(bit_ticks);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(bit_ticks - 1);

  logic [CNT_W-1:0] baud_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_cnt <= '0;
    end else if (clear || baud_cnt == LAST) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CNT_W'(1);
    end
  end

  assign tick = !clear && (baud_cnt == LAST);

endmodule

// File: rtl/uart_transmitter_for_status.sv
`timescale 1ns/1ps
// 8N1 UART transmitter for status/ack bytes to the host terminal. A one-entry
// holding register lets the next byte follow the previous stop bit with no gap.
module uart_transmitter_for_status
  import uart_pkg::*;
#(
  parameter int unsigned clk_freq  = CLK_FREQ_DEFAULT,
  parameter int unsigned baud_rate = BAUD_RATE_DEFAULT,
  parameter int unsigned bit_ticks = clk_freq / baud_rate,
  parameter int unsigned num_bit   = NUM_BIT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 TxD,
  output logic                 busy
);

  localparam logic [2:0] LAST_BIT = 3'(num_bit - 3);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] hold;
  logic                 hold_full;
  logic [2:0]           bit_idx;
  logic                 tick;
  logic                 baud_clear;
  logic                 accept;

  assign tx_ready   = !hold_full;
  assign accept     = tx_valid && !hold_full;
  assign busy       = (state != IDLE) || hold_full;
  assign baud_clear = (state == IDLE);

  uart_baud_tick #(
    .bit_ticks(bit_ticks)
  ) u_baud_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (baud_clear),
    .tick   (tick)
  );

  // Accept and load are mutually exclusive (tx_ready is low while hold is full),
  // so the hold_full updates below never collide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      shift     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      bit_idx   <= '0;
      TxD       <= 1'b1;
    end else begin
      if (accept) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          TxD <= 1'b1;
          if (hold_full) begin
            shift     <= hold;
            hold_full <= 1'b0;
            TxD       <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (tick) begin
            bit_idx <= '0;
            TxD     <= shift[0];
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
              TxD   <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              TxD     <= shift[bit_idx + 3'd1];
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (hold_full) begin
              shift     <= hold;
              hold_full <= 1'b0;
              TxD       <= 1'b0;
              state     <= START;
            end else begin
              TxD   <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: begin
          TxD   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
